// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multi-cycle MIPS control path.
// Holds state encodings, opcode constants, ALUOp / ALUSrcB / PCSource encodings
// and the control-vector struct produced by mc_out_decode.
// Optional feature macro: MULTICYCLE_ADDI_EN (adds the ADDI_EX / ADDI_WB states).
package mips_ctrl_pkg;

    // State encodings (also visible on the State debug output).
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXEC     = 4'd6;
    localparam logic [3:0] RTYPE_WB = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] JUMP     = 4'd9;
    localparam logic [3:0] ADDI_EX  = 4'd10;
    localparam logic [3:0] ADDI_WB  = 4'd11;

    // Opcode field IR[31:26].
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALUOp encodings, shared with the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_EXT     = 2'b10;
    localparam logic [1:0] SRCB_EXT_SH2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        StFetch   = FETCH,
        StDecode  = DECODE,
        StMemAdr  = MEMADR,
        StMemRd   = MEMRD,
        StMemWb   = MEMWB,
        StMemWr   = MEMWR,
        StExec    = EXEC,
        StRtypeWb = RTYPE_WB,
        StBranch  = BRANCH,
`ifdef MULTICYCLE_ADDI_EN
        StJump    = JUMP,
        StAddiEx  = ADDI_EX,
        StAddiWb  = ADDI_WB
`else
        StJump    = JUMP
`endif
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:                              legal = 1'b1;
`endif
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the control sequencer and the datapath.
// Inputs to control: Opcode, Zero, MemReady.
// Outputs from control: all datapath mux selects, write enables, PCEn,
// IllegalOp and the State debug view.
// Modports: slave (the controller), master (datapath / testbench side).
interface multicycle_control_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               Zero;
    logic               MemReady;

    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               IRWrite;
    logic               ALUSrcA;
    logic               RegWrite;
    logic               RegDst;
    logic               PCEn;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic               IllegalOp;
    logic [STATE_W-1:0] State;

    modport slave (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCEn, ALUSrcB, ALUOp, PCSource,
               IllegalOp, State
    );

    modport master (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCEn, ALUSrcB, ALUOp, PCSource,
               IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control_out_decode.sv
// mc_out_decode: combinational state -> control-vector decoder.
// Ports: state_i (current state), mem_ready_i (memory handshake, used for the
// Mealy IRWrite/PCWrite in FETCH), opcode_i (for the DECODE illegal check),
// ctrl_o (full control vector, ungated by reset).
// Optional feature macro: MULTICYCLE_ADDI_EN.
module mc_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_b  = SRCB_EXT_SH2;
                ctrl_o.illegal_op = ~op_is_legal(opcode_i);
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_EXT;
            end
            StMemRd: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            StRtypeWb: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            StJump: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_ADDI_EN
            StAddiEx: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_EXT;
            end
            StAddiWb: begin
                ctrl_o.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control sequencer for the multi-cycle MIPS datapath.
// Ports: clk (rising edge), reset (synchronous, active high), bus (slave side
// of multicycle_control_if: Opcode/Zero/MemReady in, datapath controls out).
// Holds the state register and next-state logic; output decode lives in
// mc_out_decode. Enables are forced low while reset is high so an aborted
// instruction can never write.
// Optional feature macro: MULTICYCLE_ADDI_EN (opcode 0x08 -> ADDI_EX/ADDI_WB).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.slave bus
);

    state_e state_q;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:   if (bus.MemReady) state_q <= StDecode;
                StDecode: begin
                    case (bus.Opcode)
                        OP_LW, OP_SW: state_q <= StMemAdr;
                        OP_RTYPE:     state_q <= StExec;
                        OP_BEQ:       state_q <= StBranch;
                        OP_J:         state_q <= StJump;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      state_q <= StAddiEx;
`endif
                        default:      state_q <= StFetch;
                    endcase
                end
                StMemAdr:  state_q <= (bus.Opcode == OP_LW) ? StMemRd : StMemWr;
                StMemRd:   if (bus.MemReady) state_q <= StMemWb;
                StMemWb:   state_q <= StFetch;
                StMemWr:   if (bus.MemReady) state_q <= StFetch;
                StExec:    state_q <= StRtypeWb;
                StRtypeWb: state_q <= StFetch;
                StBranch:  state_q <= StFetch;
                StJump:    state_q <= StFetch;
`ifdef MULTICYCLE_ADDI_EN
                StAddiEx:  state_q <= StAddiWb;
                StAddiWb:  state_q <= StFetch;
`endif
                default:   state_q <= StFetch;
            endcase
        end
    end

    mc_out_decode u_out_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.MemReady),
        .opcode_i    (bus.Opcode),
        .ctrl_o      (dec_ctrl)
    );

    // Mux selects pass through during reset; only side-effecting enables are killed.
    always_comb begin
        ctrl = dec_ctrl;
        if (reset) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.reg_write     = 1'b0;
            ctrl.illegal_op    = 1'b0;
        end
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.IllegalOp   = ctrl.illegal_op;
    assign bus.PCEn        = ctrl.pc_write | (ctrl.pc_write_cond & bus.Zero);
    assign bus.State       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: table of per-cycle vectors plus a stalled-lw sequence.
module tb_multicycle_control;

    logic clk;
    logic reset;

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [11:0] en;
        logic [1:0]  srcb;
        logic [1:0]  aluop;
        logic [1:0]  pcsrc;
    } vec_t;

    // Enable order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
    //               ALUSrcA RegWrite RegDst PCEn IllegalOp
    localparam logic [11:0] E_NONE  = 12'b000000000000;
    localparam logic [11:0] E_FET   = 12'b100100100010;
    localparam logic [11:0] E_FSTL  = 12'b000100000000;
    localparam logic [11:0] E_ASA   = 12'b000000010000;
    localparam logic [11:0] E_MRD   = 12'b001100000000;
    localparam logic [11:0] E_MWB   = 12'b000001001000;
    localparam logic [11:0] E_MWBR  = 12'b000001000000;
    localparam logic [11:0] E_MWR   = 12'b001010000000;
    localparam logic [11:0] E_RTW   = 12'b000000001100;
    localparam logic [11:0] E_BRZ   = 12'b010000010010;
    localparam logic [11:0] E_BRN   = 12'b010000010000;
    localparam logic [11:0] E_JMP   = 12'b100000000010;
    localparam logic [11:0] E_ILL   = 12'b000000000001;
    localparam logic [11:0] E_AWB   = 12'b000000001000;

    vec_t tbl[64];
    int   n_vec;
    int   checks;
    int   errors;

    task automatic add(input logic rst, input logic [5:0] op, input logic zero,
                       input logic rdy, input logic [3:0] st, input logic [11:0] en,
                       input logic [1:0] srcb, input logic [1:0] aluop,
                       input logic [1:0] pcsrc);
        tbl[n_vec].rst   = rst;
        tbl[n_vec].op    = op;
        tbl[n_vec].zero  = zero;
        tbl[n_vec].rdy   = rdy;
        tbl[n_vec].st    = st;
        tbl[n_vec].en    = en;
        tbl[n_vec].srcb  = srcb;
        tbl[n_vec].aluop = aluop;
        tbl[n_vec].pcsrc = pcsrc;
        n_vec++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [21:0] actual_vec();
        return {bus.State,
                bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCEn, bus.IllegalOp,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource};
    endfunction

    logic [21:0] act;
    logic [21:0] exp;
    int cyc, rw_cnt, mr_cnt, stalls;
    logic done;

    initial begin
        n_vec  = 0;
        checks = 0;
        errors = 0;
        // Reset held 3 cycles, then lw with MemReady=1.
        add(1, 6'h23, 0, 1, 4'd0, E_NONE, 2'b01, 2'b00, 2'b00);
        add(1, 6'h23, 0, 1, 4'd0, E_NONE, 2'b01, 2'b00, 2'b00);
        add(1, 6'h23, 0, 1, 4'd0, E_NONE, 2'b01, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd2, E_ASA,  2'b10, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd3, E_MRD,  2'b00, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd4, E_MWB,  2'b00, 2'b00, 2'b00);
        // sw with two stall cycles in MEMWR.
        add(0, 6'h2B, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 1, 4'd2, E_ASA,  2'b10, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 0, 4'd5, E_MWR,  2'b00, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 0, 4'd5, E_MWR,  2'b00, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 1, 4'd5, E_MWR,  2'b00, 2'b00, 2'b00);
        // R-type with one FETCH stall.
        add(0, 6'h00, 0, 0, 4'd0, E_FSTL, 2'b01, 2'b00, 2'b00);
        add(0, 6'h00, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h00, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h00, 0, 1, 4'd6, E_ASA,  2'b00, 2'b10, 2'b00);
        add(0, 6'h00, 0, 1, 4'd7, E_RTW,  2'b00, 2'b00, 2'b00);
        // beq taken, then not taken.
        add(0, 6'h04, 1, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h04, 1, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h04, 1, 1, 4'd8, E_BRZ,  2'b00, 2'b01, 2'b01);
        add(0, 6'h04, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h04, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h04, 0, 1, 4'd8, E_BRN,  2'b00, 2'b01, 2'b01);
        // j.
        add(0, 6'h02, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h02, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h02, 0, 1, 4'd9, E_JMP,  2'b00, 2'b00, 2'b10);
        // Illegal 0x3F.
        add(0, 6'h3F, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h3F, 0, 1, 4'd1, E_ILL,  2'b11, 2'b00, 2'b00);
        // addi: legal only with the macro.
        add(0, 6'h08, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
`ifdef MULTICYCLE_ADDI_EN
        add(0, 6'h08, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h08, 0, 1, 4'd10, E_ASA, 2'b10, 2'b00, 2'b00);
        add(0, 6'h08, 0, 1, 4'd11, E_AWB, 2'b00, 2'b00, 2'b00);
`else
        add(0, 6'h08, 0, 1, 4'd1, E_ILL,  2'b11, 2'b00, 2'b00);
`endif
        // lw with opcode changed in MEMRD (ignored), reset during MEMWB.
        add(0, 6'h23, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd1, E_NONE, 2'b11, 2'b00, 2'b00);
        add(0, 6'h23, 0, 1, 4'd2, E_ASA,  2'b10, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 1, 4'd3, E_MRD,  2'b00, 2'b00, 2'b00);
        add(1, 6'h2B, 0, 1, 4'd4, E_MWBR, 2'b00, 2'b00, 2'b00);
        add(0, 6'h2B, 0, 1, 4'd0, E_FET,  2'b01, 2'b00, 2'b00);

        reset        = 1'b1;
        bus.Opcode   = 6'h00;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        @(negedge clk);

        for (int i = 0; i < n_vec; i++) begin
            reset        = tbl[i].rst;
            bus.Opcode   = tbl[i].op;
            bus.Zero     = tbl[i].zero;
            bus.MemReady = tbl[i].rdy;
            #1;
            act = actual_vec();
            exp = {tbl[i].st, tbl[i].en, tbl[i].srcb, tbl[i].aluop, tbl[i].pcsrc};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got st=%0d en=%b srcb=%b aluop=%b pcsrc=%b expected st=%0d en=%b srcb=%b aluop=%b pcsrc=%b",
                         i, act[21:18], act[17:6], act[5:4], act[3:2], act[1:0],
                         exp[21:18], exp[17:6], exp[5:4], exp[3:2], exp[1:0]);
            end
            @(negedge clk);
        end

        // lw with MemReady low for the first two MEMRD cycles: 7 cycles total.
        reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.Opcode   = 6'h23;
        bus.MemReady = 1'b1;
        cyc    = 0;
        rw_cnt = 0;
        mr_cnt = 0;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.State == 4'd3 && stalls < 2) begin
                bus.MemReady = 1'b0;
                stalls++;
            end else begin
                bus.MemReady = 1'b1;
            end
            #1;
            if (bus.RegWrite) rw_cnt++;
            if (bus.State == 4'd3 && bus.MemRead && bus.IorD) mr_cnt++;
            cyc++;
            @(negedge clk);
            if (bus.State == 4'd0) done = 1'b1;
        end
        check("lw_stall_done", int'(done), 1);
        check("lw_stall_cycles", cyc, 7);
        check("lw_stall_regwrite", rw_cnt, 1);
        check("lw_stall_memrd_held", mr_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
